gomoku_win_scanner: RTL and testbench

GOMOKU_WIN_SCANNER -- requirements
Module: gomoku_win_scanner

---
 rtl/gomoku_pkg.sv | 30 +++
 rtl/gomoku_step.sv | 71 +++++++
 rtl/gomoku_win_scanner.sv | 199 +++++++++++++++++++
 tb/tb_gomoku_win_scanner.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gomoku_pkg.sv
// gomoku_pkg
// Shared definitions for the Gomoku win scanner:
//   - state_e    : scanner FSM states
//   - dir_e      : direction encoding reported on the dir output
//   - DIR_DR/DC  : per-direction (row, col) step, indexed by dir_e
//   - DEFAULT_BOARD_N / DEFAULT_WIN_LEN : standard 15x15 board, five in a row
package gomoku_pkg;

   localparam int DEFAULT_BOARD_N = 15;
   localparam int DEFAULT_WIN_LEN = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WALK_POS = 2'd1,
      WALK_NEG = 2'd2,
      DONE     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      DIR_H = 2'd0,
      DIR_V = 2'd1,
      DIR_D = 2'd2,
      DIR_A = 2'd3
   } dir_e;

   // Positive step of each direction; the negative walk simply negates it.
   localparam logic signed [1:0] DIR_DR [4] = '{2'sd0, 2'sd1, 2'sd1,  2'sd1};
   localparam logic signed [1:0] DIR_DC [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

endpackage

// File: rtl/gomoku_step.sv
// gomoku_step
// Combinational address generator: origin +/- k*(dr,dc) for direction d.
// Ports:
//   origin_row, origin_col : walk origin
//   d                      : direction (dir_e encoding)
//   k                      : step distance from origin
//   neg                    : 1 walks against the direction
//   tgt_row, tgt_col       : target coordinate (low bits, valid when in_bounds)
//   in_bounds              : target lies on the board
//   bit_idx                : flat board index row*BOARD_N+col of the target
module gomoku_step
   import gomoku_pkg::*;
#(
   parameter int BOARD_N = DEFAULT_BOARD_N
)(
   input  logic [$clog2(BOARD_N)-1:0]         origin_row,
   input  logic [$clog2(BOARD_N)-1:0]         origin_col,
   input  logic [1:0]                         d,
   input  logic [$clog2(BOARD_N)-1:0]         k,
   input  logic                               neg,
   output logic [$clog2(BOARD_N)-1:0]         tgt_row,
   output logic [$clog2(BOARD_N)-1:0]         tgt_col,
   output logic                               in_bounds,
   output logic [$clog2(BOARD_N*BOARD_N)-1:0] bit_idx
);

   localparam int COORD_W = $clog2(BOARD_N);
   localparam int IDX_W   = $clog2(BOARD_N*BOARD_N);
   // Two extra bits: one for the sign, one so origin+k never overflows.
   localparam int SW      = COORD_W + 2;
   localparam logic signed [SW-1:0] LIMIT = SW'(BOARD_N);

   logic signed [1:0]    dr;
   logic signed [1:0]    dc;
   logic signed [SW-1:0] k_s;
   logic signed [SW-1:0] off_r;
   logic signed [SW-1:0] off_c;
   logic signed [SW-1:0] r_s;
   logic signed [SW-1:0] c_s;

   // Target computed in signed arithmetic so a step off the left/top edge
   // goes negative instead of wrapping into the neighbouring row.
   always_comb begin
      dr    = DIR_DR[d];
      dc    = DIR_DC[d];
      k_s   = signed'({2'b00, k});
      off_r = '0;
      off_c = '0;
      if (dr == 2'sd1) begin
         off_r = k_s;
      end else if (dr == -2'sd1) begin
         off_r = -k_s;
      end
      if (dc == 2'sd1) begin
         off_c = k_s;
      end else if (dc == -2'sd1) begin
         off_c = -k_s;
      end
      if (neg) begin
         off_r = -off_r;
         off_c = -off_c;
      end
      r_s       = signed'({2'b00, origin_row}) + off_r;
      c_s       = signed'({2'b00, origin_col}) + off_c;
      in_bounds = !r_s[SW-1] && (r_s < LIMIT) && !c_s[SW-1] && (c_s < LIMIT);
      tgt_row   = r_s[COORD_W-1:0];
      tgt_col   = c_s[COORD_W-1:0];
      bit_idx   = IDX_W'(tgt_row) * IDX_W'(BOARD_N) + IDX_W'(tgt_col);
   end

endmodule

// File: rtl/gomoku_win_scanner.sv
// gomoku_win_scanner
// Checks whether the stone just placed at (row,col) completes a run of at
// least WIN_LEN stones in any of the four line directions. One cell is
// examined per clock, walking outward from the origin in both senses.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : scan request, taken only when idle
//   row, col   : coordinate of the last placed stone
//   board      : one player's stones, bit row*BOARD_N+col
//   busy       : scanner not idle
//   done       : one-cycle pulse when win/dir/err are valid
//   win, dir   : run found and its direction (0 H, 1 V, 2 diag, 3 anti-diag)
//   err        : requested coordinate was off the board
module gomoku_win_scanner
   import gomoku_pkg::*;
#(
   parameter int BOARD_N = DEFAULT_BOARD_N,
   parameter int WIN_LEN = DEFAULT_WIN_LEN
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(BOARD_N)-1:0]   row,
   input  logic [$clog2(BOARD_N)-1:0]   col,
   input  logic [BOARD_N*BOARD_N-1:0]   board,
   output logic                         busy,
   output logic                         done,
   output logic                         win,
   output logic [1:0]                   dir,
   output logic                         err
);

   localparam int COORD_W = $clog2(BOARD_N);
   localparam int CW      = $clog2(WIN_LEN + 1);
   localparam int IDX_W   = $clog2(BOARD_N*BOARD_N);
   localparam int CELLS   = BOARD_N * BOARD_N;

   state_e               state_q, state_n;
   logic [COORD_W-1:0]   row_q, row_n;
   logic [COORD_W-1:0]   col_q, col_n;
   logic [CELLS-1:0]     snap_q, snap_n;
   dir_e                 d_q, d_n;
   logic [CW-1:0]        count_q, count_n;
   logic [COORD_W-1:0]   k_q, k_n;
   logic                 win_q, win_n;
   logic [1:0]           dir_q, dir_n;
   logic                 err_q, err_n;

   logic [COORD_W-1:0]   step_row;
   logic [COORD_W-1:0]   step_col;
   logic [1:0]           step_d;
   logic [COORD_W-1:0]   step_k;
   logic                 step_neg;
   logic                 in_bounds;
   logic [IDX_W-1:0]     bit_idx;
   logic                 cell_bit;
   logic                 cell_set;
   // The walk only needs the flat index; coordinates are left for debug.
   logic [COORD_W-1:0]   unused_tgt_row;
   logic [COORD_W-1:0]   unused_tgt_col;

   // While idle the stepper is fed the live inputs with k=0, so its bounds
   // flag doubles as the coordinate range check and its index addresses
   // the origin stone on the live board.
   always_comb begin
      step_row = row_q;
      step_col = col_q;
      step_d   = d_q;
      step_k   = k_q;
      step_neg = (state_q == WALK_NEG);
      cell_bit = snap_q[bit_idx];
      if (state_q == IDLE) begin
         step_row = row;
         step_col = col;
         step_d   = DIR_H;
         step_k   = '0;
         cell_bit = board[bit_idx];
      end
      cell_set = in_bounds && cell_bit;
   end

   gomoku_step #(
      .BOARD_N (BOARD_N)
   ) u_step (
      .origin_row (step_row),
      .origin_col (step_col),
      .d          (step_d),
      .k          (step_k),
      .neg        (step_neg),
      .tgt_row    (unused_tgt_row),
      .tgt_col    (unused_tgt_col),
      .in_bounds  (in_bounds),
      .bit_idx    (bit_idx)
   );

   // State and datapath registers; reset aborts any scan without a done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         snap_q  <= '0;
         d_q     <= DIR_H;
         count_q <= '0;
         k_q     <= '0;
         win_q   <= 1'b0;
         dir_q   <= 2'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         row_q   <= row_n;
         col_q   <= col_n;
         snap_q  <= snap_n;
         d_q     <= d_n;
         count_q <= count_n;
         k_q     <= k_n;
         win_q   <= win_n;
         dir_q   <= dir_n;
         err_q   <= err_n;
      end
   end

   // Next-state logic. Each walk cycle looks at one cell: a stone extends
   // the run and pushes one step further, anything else turns the walk
   // around (positive -> negative) or moves to the next direction.
   always_comb begin
      state_n = state_q;
      row_n   = row_q;
      col_n   = col_q;
      snap_n  = snap_q;
      d_n     = d_q;
      count_n = count_q;
      k_n     = k_q;
      win_n   = win_q;
      dir_n   = dir_q;
      err_n   = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               row_n   = row;
               col_n   = col;
               snap_n  = board;
               win_n   = 1'b0;
               dir_n   = 2'd0;
               err_n   = 1'b0;
               d_n     = DIR_H;
               count_n = CW'(1);
               k_n     = COORD_W'(1);
               if (!in_bounds) begin
                  err_n   = 1'b1;
                  state_n = DONE;
               end else if (!cell_bit) begin
                  state_n = DONE;
               end else begin
                  state_n = WALK_POS;
               end
            end
         end
         WALK_POS, WALK_NEG: begin
            if (cell_set) begin
               count_n = count_q + 1'b1;
               k_n     = k_q + 1'b1;
               // This stone completes the run; longer runs stop here too.
               if (count_q == CW'(WIN_LEN - 1)) begin
                  win_n   = 1'b1;
                  dir_n   = d_q;
                  state_n = DONE;
               end
            end else if (state_q == WALK_POS) begin
               k_n     = COORD_W'(1);
               state_n = WALK_NEG;
            end else if (d_q == DIR_A) begin
               state_n = DONE;
            end else begin
               d_n     = dir_e'(d_q + 2'd1);
               count_n = CW'(1);
               k_n     = COORD_W'(1);
               state_n = WALK_POS;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Outputs are straight decodes of registered state.
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
      win  = win_q;
      dir  = dir_q;
      err  = err_q;
   end

endmodule

// File: tb/tb_gomoku_win_scanner.sv
// tb_gomoku_win_scanner
// Self-checking bench for gomoku_win_scanner on a 15x15 board, five to win.
// Fixed vectors with hand-derived results, randomized boards checked against
// a line-walking reference model, and hand-written multi-cycle sequences.
module tb_gomoku_win_scanner;

   localparam int N     = 15;
   localparam int WL    = 5;
   localparam int CELLS = N * N;
   localparam int BOUND = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [3:0]       row;
   logic [3:0]       col;
   logic [CELLS-1:0] board;
   logic             busy;
   logic             done;
   logic             win;
   logic [1:0]       dir;
   logic             err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string            name;
      logic [CELLS-1:0] board;
      int               row;
      int               col;
      int               exp_win;
      int               exp_dir;
      int               exp_err;
      int               exp_lat;
   } vec_t;

   vec_t vecs[10];

   gomoku_win_scanner #(
      .BOARD_N (N),
      .WIN_LEN (WL)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .row   (row),
      .col   (col),
      .board (board),
      .busy  (busy),
      .done  (done),
      .win   (win),
      .dir   (dir),
      .err   (err)
   );

   always #5 clk = ~clk;

   function automatic logic [CELLS-1:0] put(input logic [CELLS-1:0] b, input int r, input int c);
      b[r*N+c] = 1'b1;
      return b;
   endfunction

   function automatic bit stone(input logic [CELLS-1:0] b, input int r, input int c);
      if (r < 0 || r >= N || c < 0 || c >= N) return 1'b0;
      return b[r*N+c];
   endfunction

   // Reference: walk each line from the origin, counting one examined cell
   // per probe including the probe that ends each half-line.
   function automatic void model(input logic [CELLS-1:0] b, input int r, input int c,
                                 output int ew, output int ed, output int ee, output int el);
      int dr_t[4] = '{0, 1, 1, 1};
      int dc_t[4] = '{1, 0, 1, -1};
      ew = 0; ed = 0; ee = 0; el = 0;
      if (r >= N || c >= N) begin
         ee = 1;
         return;
      end
      if (!stone(b, r, c)) return;
      for (int d = 0; d < 4; d++) begin
         int run;
         run = 1;
         for (int s = 1; s >= -1; s -= 2) begin
            int k;
            k = 1;
            while (1) begin
               el++;
               if (stone(b, r + s*k*dr_t[d], c + s*k*dc_t[d])) begin
                  run++;
                  if (run >= WL) begin
                     ew = 1;
                     ed = d;
                     return;
                  end
                  k++;
               end else begin
                  break;
               end
            end
         end
      end
   endfunction

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Called about 1 time unit after a rising edge; returns at the same
   // phase just after the start edge.
   task automatic apply_stimulus(input logic [CELLS-1:0] b, input int r, input int c);
      row   = 4'(r);
      col   = 4'(c);
      board = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < BOUND) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_scan(input string name, input logic [CELLS-1:0] b, input int r, input int c,
                           input int ew, input int ed, input int ee, input int el);
      int lat;
      apply_stimulus(b, r, c);
      check_output({name, "_busy"}, int'(busy), 1);
      wait_done(lat);
      check_output({name, "_latency"}, lat, el);
      check_output({name, "_win"}, int'(win), ew);
      check_output({name, "_dir"}, int'(dir), ed);
      check_output({name, "_err"}, int'(err), ee);
      @(posedge clk);
      #1;
      check_output({name, "_done_width"}, int'(done), 0);
      check_output({name, "_idle"}, int'(busy), 0);
      check_output({name, "_win_hold"}, int'(win), ew);
   endtask

   initial begin
      logic [CELLS-1:0] b;
      int ew, ed, ee, el, lat, pulses;

      // Fixed vectors with hand-derived results.
      b = '0;
      b = put(b, 7, 7); b = put(b, 8, 6); b = put(b, 9, 5); b = put(b, 6, 8); b = put(b, 5, 9);
      vecs[0] = '{"anti_diag", b, 7, 7, 1, 3, 0, 11};
      vecs[1] = '{"lone_corner", put('0, 0, 0), 0, 0, 0, 0, 0, 8};
      vecs[2] = '{"empty_origin", '0, 4, 4, 0, 0, 0, 0};
      vecs[3] = '{"row_oob", put('0, 0, 0), 15, 0, 0, 0, 1, 0};
      b = '0;
      for (int c = 2; c <= 6; c++) b = put(b, 3, c);
      vecs[4] = '{"horiz_mid", b, 3, 4, 1, 0, 0, 5};
      b = '0;
      for (int r = 0; r <= 4; r++) b = put(b, r, 10);
      vecs[5] = '{"vert_top", b, 0, 10, 1, 1, 0, 6};
      b = '0;
      for (int i = 10; i <= 14; i++) b = put(b, i, i);
      vecs[6] = '{"diag_corner", b, 14, 14, 1, 2, 0, 9};
      b = '0;
      b = put(b, 5, 0); b = put(b, 5, 1); b = put(b, 5, 2); b = put(b, 4, 14); b = put(b, 4, 13);
      vecs[7] = '{"no_row_wrap", b, 5, 0, 0, 0, 0, 10};
      b = '0;
      for (int c = 4; c <= 9; c++) b = put(b, 12, c);
      vecs[8] = '{"run_of_six", b, 12, 9, 1, 0, 0, 5};
      vecs[9] = '{"col_oob", put('0, 3, 3), 3, 15, 0, 0, 1, 0};

      rst   = 1'b0;
      start = 1'b0;
      row   = '0;
      col   = '0;
      board = '0;
      #1 rst = 1'b1;
      #10;
      check_output("reset_busy", int'(busy), 0);
      check_output("reset_done", int'(done), 0);
      check_output("reset_win", int'(win), 0);
      check_output("reset_dir", int'(dir), 0);
      check_output("reset_err", int'(err), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_scan(vecs[i].name, vecs[i].board, vecs[i].row, vecs[i].col,
                  vecs[i].exp_win, vecs[i].exp_dir, vecs[i].exp_err, vecs[i].exp_lat);
      end

      // Board and coordinates change one cycle after acceptance; the
      // scan must keep using the snapshot and lose the would-be win.
      b = '0;
      for (int c = 3; c <= 6; c++) b = put(b, 7, c);
      apply_stimulus(b, 7, 6);
      board = put(b, 7, 7);
      row   = 4'd0;
      col   = 4'd0;
      wait_done(lat);
      check_output("snapshot_latency", lat, 11);
      check_output("snapshot_win", int'(win), 0);
      @(posedge clk);
      #1;

      // Reset on the third walk cycle after a winning scan left win=1.
      run_scan("pre_reset", vecs[6].board, 14, 14, 1, 2, 0, 9);
      apply_stimulus(vecs[0].board, 7, 7);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_output("midreset_busy", int'(busy), 0);
      check_output("midreset_done", int'(done), 0);
      check_output("midreset_win", int'(win), 0);
      check_output("midreset_dir", int'(dir), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) pulses++;
      end
      check_output("midreset_no_done", pulses, 0);
      run_scan("post_reset", vecs[4].board, 3, 4, 1, 0, 0, 5);

      // start held high for the whole scan: one accepted start, one done.
      row   = 4'd3;
      col   = 4'd4;
      board = vecs[4].board;
      start = 1'b1;
      @(posedge clk);
      #1;
      wait_done(lat);
      start = 1'b0;
      check_output("held_start_latency", lat, 5);
      check_output("held_start_win", int'(win), 1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) pulses++;
      end
      check_output("held_start_extra_done", pulses, 0);

      // Randomized boards against the reference model.
      for (int it = 0; it < 40; it++) begin
         int dens, r, c;
         dens = int'($urandom_range(15, 55));
         for (int i = 0; i < CELLS; i++) b[i] = ($urandom_range(0, 99) < dens);
         r = int'($urandom_range(0, 15));
         c = int'($urandom_range(0, 15));
         if (r < N && c < N && $urandom_range(0, 9) < 8) b = put(b, r, c);
         model(b, r, c, ew, ed, ee, el);
         run_scan($sformatf("rand%0d", it), b, r, c, ew, ed, ee, el);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
